// File: rtl/bench_stim_pkg.sv
// Shared types and constants for the operand/start stimulus sequencer.
package bench_stim_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_LFSR  = 2'd0;
    localparam logic [1:0] MODE_SWEEP = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;
    localparam logic [1:0] MODE_HOLD  = 2'd3;

endpackage

// File: rtl/stim_opgen.sv
// Next-value generator for one operand; DIR=0 steps up/left, DIR=1 steps down/right.
module stim_opgen
    import bench_stim_pkg::*;
#(
    parameter int unsigned    N    = 16,
    parameter logic [N-1:0]   TAPS = N'(16'hB400),
    parameter logic [N-1:0]   SEED = N'(1),
    parameter bit             DIR  = 1'b0
) (
    input  logic [N-1:0] cur,
    input  logic [1:0]   mode,
    output logic [N-1:0] nxt_c
);

    // A zero register would lock up the LFSR and the walking bit, so reload.
    localparam logic [N-1:0] WALK_INIT = DIR ? (N'(1) << (N - 1)) : N'(1);

    always_comb begin
        nxt_c = cur;
        case (mode)
            MODE_LFSR: begin
                if (cur == '0) nxt_c = SEED;
                else           nxt_c = (cur >> 1) ^ (cur[0] ? TAPS : '0);
            end
            MODE_SWEEP: nxt_c = DIR ? (cur - N'(1)) : (cur + N'(1));
            MODE_WALK: begin
                if (cur == '0) nxt_c = WALK_INIT;
                else if (DIR)  nxt_c = {cur[0], cur[N-1:1]};
                else           nxt_c = {cur[N-2:0], cur[N-1]};
            end
            default: nxt_c = cur;
        endcase
    end

endmodule

// File: rtl/bench_stim_seq.sv
// Operand/start sequencer: drives a, b and a one-cycle strt per transaction,
// each transaction lasting PERIOD cycles or ending early on done.
module bench_stim_seq
    import bench_stim_pkg::*;
#(
    parameter int unsigned  N         = 16,
    parameter int unsigned  PERIOD    = 31,
    parameter bit           WAIT_DONE = 1'b0,
    parameter logic [N-1:0] SEED_A    = N'(16'hACE1),
    parameter logic [N-1:0] SEED_B    = N'(16'h1D0F),
    parameter logic [N-1:0] TAPS      = N'(16'hB400),
    parameter int unsigned  MAX_TXN   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             done,
    output logic [N-1:0]     a,
    output logic [N-1:0]     b,
    output logic             strt,
    output logic             busy,
    output logic             timeout,
    output logic             finished,
    output logic [CNT_W-1:0] txn_cnt
);

    localparam int unsigned      TW      = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d;
    logic [N-1:0]     a_nxt_c, b_nxt_c;
    logic [TW-1:0]    timer_q, timer_d;
    logic             strt_q, strt_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic             finished_q, finished_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic             in_wait_c, done_hit_c, expire_c, end_c, hit_max_c;

    stim_opgen #(.N(N), .TAPS(TAPS), .SEED(SEED_A), .DIR(1'b0)) u_gen_a (
        .cur   (a_q),
        .mode  (mode),
        .nxt_c (a_nxt_c)
    );

    stim_opgen #(.N(N), .TAPS(TAPS), .SEED(SEED_B), .DIR(1'b1)) u_gen_b (
        .cur   (b_q),
        .mode  (mode),
        .nxt_c (b_nxt_c)
    );

    // Done takes priority over a simultaneous timer expiry.
    assign in_wait_c  = (state_q == WAIT);
    assign done_hit_c = WAIT_DONE && done;
    assign expire_c   = in_wait_c && !done_hit_c && (timer_q == '0);
    assign end_c      = in_wait_c && (done_hit_c || (timer_q == '0));
    assign cnt_inc_c  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
    assign hit_max_c  = (MAX_TXN != 0) && (cnt_inc_c == CNT_W'(MAX_TXN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= SEED_A;
            b_q        <= SEED_B;
            timer_q    <= '0;
            strt_q     <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            finished_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            timer_q    <= timer_d;
            strt_q     <= strt_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            finished_q <= finished_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en && !finished_q) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (end_c) state_d = (hit_max_c || !en) ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and datapath follow the state being entered.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        finished_d = finished_q;
        strt_d     = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);

        if (state_q == ISSUE) timer_d = TW'(PERIOD - 2);
        if (in_wait_c && !end_c) timer_d = timer_q - TW'(1);

        if (end_c) begin
            a_d   = a_nxt_c;
            b_d   = b_nxt_c;
            cnt_d = cnt_inc_c;
            if (hit_max_c) finished_d = 1'b1;
        end

        if (WAIT_DONE && expire_c) timeout_d = 1'b1;
    end

    assign a        = a_q;
    assign b        = b_q;
    assign strt     = strt_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;
    assign finished = finished_q;
    assign txn_cnt  = cnt_q;

endmodule
